pipe_ctrl_unit: RTL

// - Pipelined control unit for the 5-stage RV32I core: decodes instr_d in ID, carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
// - Generates load-use stall, branch/jump flush and EX operand-forward selects.
// - Decodes I-type shifts and flags illegal opcodes.
// - Sits between the IF/ID register and the datapath; the datapath holds data, this block holds all control state.

---
 rtl/pipe_ctrl_unit.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: control unit for a 5-stage RV32I pipeline.
// It decodes instr_d in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB.
// It also produces the load-use stall, the branch/jump redirect and flush, and the EX forward selects.
// Optional feature: define CTRL_MDEXT_EN to decode MUL..REMU. DIV*/REM* then hold EX for MD_CYCLES cycles.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_d                       ID-stage instruction
//   br_taken_e                    branch comparator result for the EX instruction
//   illegal_d                     ID instruction not decodable (combinational)
//   stall_f, stall_d, flush_d     PC hold, IF/ID hold, IF/ID clear
//   redirect_e                    PC takes the EX target
//   alu_control_e, sel_a_e, sel_b_e, br_type_e, fwd_a_e, fwd_b_e   EX controls
//   rd_en_m, wr_n_m, cs_n_m, func3_m                               data-memory controls
//   regwrite_w, wb_sel_w, rd_w                                     writeback controls
//   md_op_e, md_start_e, md_busy                                   M-extension handshake
module pipe_ctrl_unit #(
    parameter int ALU_W     = 4,
    parameter int REG_AW    = 5,
    parameter int BR_W      = 3,
    parameter int MD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_d,
    input  logic              br_taken_e,
    output logic              illegal_d,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              redirect_e,
    output logic [ALU_W-1:0]  alu_control_e,
    output logic              sel_a_e,
    output logic              sel_b_e,
    output logic [BR_W-1:0]   br_type_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              rd_en_m,
    output logic              wr_n_m,
    output logic              cs_n_m,
    output logic [2:0]        func3_m,
    output logic              regwrite_w,
    output logic [1:0]        wb_sel_w,
    output logic [REG_AW-1:0] rd_w,
    output logic [2:0]        md_op_e,
    output logic              md_start_e,
    output logic              md_busy
);
    localparam logic [ALU_W-1:0] A_ADD = ALU_W'(0), A_SUB = ALU_W'(1), A_SLL = ALU_W'(2),
        A_SLT = ALU_W'(3), A_SLTU = ALU_W'(4), A_XOR = ALU_W'(5), A_SRL = ALU_W'(6),
        A_SRA = ALU_W'(7), A_OR = ALU_W'(8), A_AND = ALU_W'(9), A_COPYB = ALU_W'(10);
    typedef struct packed {
        logic              regwrite;
        logic              rd_en;
        logic              wr;
        logic [ALU_W-1:0]  alu;
        logic              sel_a;
        logic              sel_b;
        logic [BR_W-1:0]   br;
        logic              branch;
        logic              jal;
        logic              jalr;
        logic [1:0]        wb;
        logic [2:0]        f3;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } ex_t;
    typedef struct packed {
        logic              regwrite;
        logic              rd_en;
        logic              wr;
        logic [1:0]        wb;
        logic [2:0]        f3;
        logic [REG_AW-1:0] rd;
    } mem_t;
    typedef struct packed {
        logic              regwrite;
        logic [1:0]        wb;
        logic [REG_AW-1:0] rd;
    } wb_t;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [ALU_W-1:0] alu_f3;
    logic ok, use1, use2, dec_md, ld_use, redirect, md_hold, enter;
    ex_t dec, ex_q, ex_d;
    mem_t mem_q, mem_d;
    wb_t wb_q, wb_d;
    assign op = instr_d[6:0];
    assign f3 = instr_d[14:12];
    assign f7 = instr_d[31:25];
    always_comb begin
        case (f3)
            3'b000: alu_f3 = A_ADD;
            3'b001: alu_f3 = A_SLL;
            3'b010: alu_f3 = A_SLT;
            3'b011: alu_f3 = A_SLTU;
            3'b100: alu_f3 = A_XOR;
            3'b101: alu_f3 = A_SRL;
            3'b110: alu_f3 = A_OR;
            default: alu_f3 = A_AND;
        endcase
    end
    // Unused source fields decode as x0 so that hazard and forward compares need no extra qualifiers.
    always_comb begin
        dec = '0;
        ok = 1'b0;
        use1 = 1'b0;
        use2 = 1'b0;
        dec_md = 1'b0;
        case (op)
            7'b0110011: begin
                use1 = 1'b1;
                use2 = 1'b1;
                dec.regwrite = 1'b1;
                if (f7 == 7'b0000000) begin
                    ok = 1'b1;
                    dec.alu = alu_f3;
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    ok = 1'b1;
                    dec.alu = f3[2] ? A_SRA : A_SUB;
                end
`ifdef CTRL_MDEXT_EN
                else if (f7 == 7'b0000001) begin
                    ok = 1'b1;
                    dec_md = 1'b1;
                end
`endif
            end
            7'b0010011: begin
                use1 = 1'b1;
                dec.regwrite = 1'b1;
                dec.sel_b = 1'b1;
                ok = f3 == 3'b001 ? f7 == 7'b0000000 :
                     f3 == 3'b101 ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;
                dec.alu = (f3 == 3'b101 && f7[5]) ? A_SRA : alu_f3;
            end
            7'b0000011: begin
                use1 = 1'b1;
                ok = f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111;
                dec.regwrite = 1'b1;
                dec.rd_en = 1'b1;
                dec.sel_b = 1'b1;
                dec.wb = 2'b01;
            end
            7'b0100011: begin
                use1 = 1'b1;
                use2 = 1'b1;
                ok = f3 < 3'd3;
                dec.wr = 1'b1;
                dec.sel_b = 1'b1;
            end
            7'b0110111: begin
                ok = 1'b1;
                dec.regwrite = 1'b1;
                dec.sel_b = 1'b1;
                dec.alu = A_COPYB;
            end
            7'b0010111: begin
                ok = 1'b1;
                dec.regwrite = 1'b1;
                dec.sel_a = 1'b1;
                dec.sel_b = 1'b1;
            end
            7'b1100011: begin
                use1 = 1'b1;
                use2 = 1'b1;
                ok = f3 != 3'b010 && f3 != 3'b011;
                dec.branch = 1'b1;
                dec.sel_a = 1'b1;
                dec.sel_b = 1'b1;
                // BLT..BGEU (func3 4..7) pack down to codes 2..5
                dec.br = f3[2] ? BR_W'(f3 - 3'd2) : BR_W'(f3);
            end
            7'b1101111: begin
                ok = 1'b1;
                dec.regwrite = 1'b1;
                dec.jal = 1'b1;
                dec.sel_a = 1'b1;
                dec.sel_b = 1'b1;
                dec.wb = 2'b10;
            end
            7'b1100111: begin
                use1 = 1'b1;
                ok = f3 == 3'b000;
                dec.regwrite = 1'b1;
                dec.jalr = 1'b1;
                dec.sel_b = 1'b1;
                dec.wb = 2'b10;
            end
            default: ;
        endcase
        dec.f3 = f3;
        dec.rd = dec.regwrite ? REG_AW'(instr_d[11:7]) : '0;
        dec.rs1 = use1 ? REG_AW'(instr_d[19:15]) : '0;
        dec.rs2 = use2 ? REG_AW'(instr_d[24:20]) : '0;
        if (!ok) begin
            dec = '0;
            dec_md = 1'b0;
        end
    end
    always_comb begin
        ld_use = ex_q.rd_en && ex_q.rd != '0 && (dec.rs1 == ex_q.rd || dec.rs2 == ex_q.rd);
        redirect = (ex_q.branch & br_taken_e) | ex_q.jal | ex_q.jalr;
        enter = !(redirect || ld_use);
        ex_d = md_hold ? ex_q : enter ? dec : '0;
        mem_d = md_hold ? '0 : '{regwrite: ex_q.regwrite, rd_en: ex_q.rd_en, wr: ex_q.wr,
                                 wb: ex_q.wb, f3: ex_q.f3, rd: ex_q.rd};
        wb_d = '{regwrite: mem_q.regwrite, wb: mem_q.wb, rd: mem_q.rd};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
            mem_q <= '0;
            wb_q <= '0;
        end else begin
            ex_q <= ex_d;
            mem_q <= mem_d;
            wb_q <= wb_d;
        end
    end
`ifdef CTRL_MDEXT_EN
    localparam int CW = $clog2(MD_CYCLES);
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic md_start_q, md_start_d, md_ex_q, md_ex_d;
    // While the divider counts, EX is frozen, so the M flag and counter only change on a fresh entry.
    always_comb begin
        md_start_d = !md_hold && enter && dec_md;
        md_ex_d = md_hold ? md_ex_q : enter && dec_md;
        md_cnt_d = md_hold ? md_cnt_q - CW'(1) : (md_start_d && dec.f3[2]) ? CW'(MD_CYCLES - 1) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_q <= '0;
            md_start_q <= 1'b0;
            md_ex_q <= 1'b0;
        end else begin
            md_cnt_q <= md_cnt_d;
            md_start_q <= md_start_d;
            md_ex_q <= md_ex_d;
        end
    end
    assign md_hold = md_cnt_q != '0;
    assign md_busy = md_hold;
    assign md_start_e = md_start_q;
    assign md_op_e = md_ex_q ? ex_q.f3 : 3'b000;
`else
    assign md_hold = 1'b0;
    assign md_busy = 1'b0;
    assign md_start_e = 1'b0;
    assign md_op_e = 3'b000;
`endif
    // A redirect squashes the ID instruction, so any load-use stall it raised is moot.
    assign stall_f = !redirect && (ld_use || md_hold);
    assign stall_d = stall_f;
    assign flush_d = redirect;
    assign redirect_e = redirect;
    assign illegal_d = !ok;
    assign alu_control_e = ex_q.alu;
    assign sel_a_e = ex_q.sel_a;
    assign sel_b_e = ex_q.sel_b;
    assign br_type_e = ex_q.br;
    assign fwd_a_e = (mem_q.regwrite && mem_q.rd != '0 && mem_q.rd == ex_q.rs1) ? 2'b01 :
                     (wb_q.regwrite && wb_q.rd != '0 && wb_q.rd == ex_q.rs1) ? 2'b10 : 2'b00;
    assign fwd_b_e = (mem_q.regwrite && mem_q.rd != '0 && mem_q.rd == ex_q.rs2) ? 2'b01 :
                     (wb_q.regwrite && wb_q.rd != '0 && wb_q.rd == ex_q.rs2) ? 2'b10 : 2'b00;
    assign rd_en_m = mem_q.rd_en;
    assign wr_n_m = !mem_q.wr;
    assign cs_n_m = !(mem_q.rd_en || mem_q.wr);
    assign func3_m = mem_q.f3;
    assign regwrite_w = wb_q.regwrite;
    assign wb_sel_w = wb_q.wb;
    assign rd_w = wb_q.rd;
endmodule
